// File: rtl/avst_fifo_pkg.sv
// Shared constants for the parametrised Avalon-ST FIFO: default geometry,
// statistics counter width and the fill/pointer width helper.
package avst_fifo_pkg;

    localparam int unsigned DefaultDepth     = 8;
    localparam int unsigned DefaultDataWidth = 26;
    localparam int unsigned StatsWidth       = 16;

    // Pointers and the fill level carry one extra bit so that 0..DEPTH is representable.
    function automatic int unsigned fill_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/avst_fifo_ram.sv
// Simple dual-port storage: synchronous write, synchronous read-old-data, no reset.
module avst_fifo_ram #(
    parameter int unsigned DATA_WIDTH = 26,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/avst_param_fifo.sv
// Parametrised Avalon-ST buffering FIFO with registered fill level and threshold flags.
// Optional statistics (overflow count, high-water mark) are enabled by AVST_FIFO_STATS_EN.
module avst_param_fifo
    import avst_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefaultDataWidth,
    parameter int unsigned DEPTH      = DefaultDepth,
    parameter int unsigned AF_THRESH  = DEPTH - 2,
    parameter int unsigned AE_THRESH  = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    in_ready,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [$clog2(DEPTH):0]  fill_level,
    output logic                    almost_full,
    output logic                    almost_empty
`ifdef AVST_FIFO_STATS_EN
    ,
    input  logic                    stats_clr,
    output logic [StatsWidth-1:0]   ovf_count,
    output logic [$clog2(DEPTH):0]  hwm
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned FW = fill_width(DEPTH);

    localparam logic [FW-1:0] AfLevel = FW'(AF_THRESH);
    localparam logic [FW-1:0] AeLevel = FW'(AE_THRESH);
    localparam logic [FW-1:0] FillOne = FW'(1);

    logic [FW-1:0]         wptr_q, rptr_q, rptr_d;
    logic [FW-1:0]         fill_q, fill_d;
    logic                  out_valid_q, out_valid_d;
    logic                  af_q, ae_q;
    logic                  full, push, pop;
    logic [DATA_WIDTH-1:0] rd_data;

    assign full     = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign pop      = out_valid_q && out_ready;

    always_comb begin
        rptr_d = rptr_q;
        fill_d = fill_q;
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase
        // The RAM read register holds the word at the post-pop read pointer, but only
        // words already stored before this edge are readable; a word written this edge
        // shows up one cycle later, which is the single-cycle bubble on an empty FIFO.
        out_valid_d = pop ? (fill_q > FillOne) : (fill_q != '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            af_q        <= 1'b0;
            ae_q        <= 1'b1;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            rptr_q      <= rptr_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            af_q        <= (fill_d >= AfLevel);
            ae_q        <= (fill_d <= AeLevel);
        end
    end

    avst_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wptr_q[AW-1:0]),
        .wr_data (in_data),
        .rd_addr (rptr_d[AW-1:0]),
        .rd_data (rd_data)
    );

    // The RAM has no reset, so the payload is forced to zero while nothing is presented.
    assign out_data     = out_valid_q ? rd_data : '0;
    assign out_valid    = out_valid_q;
    assign fill_level   = fill_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;

`ifdef AVST_FIFO_STATS_EN
    logic [StatsWidth-1:0] ovf_q;
    logic [FW-1:0]         hwm_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= '0;
            hwm_q <= '0;
        end else if (stats_clr) begin
            ovf_q <= '0;
            hwm_q <= '0;
        end else begin
            if (in_valid && full && (ovf_q != '1)) begin
                ovf_q <= ovf_q + 1'b1;
            end
            if (fill_d > hwm_q) begin
                hwm_q <= fill_d;
            end
        end
    end

    assign ovf_count = ovf_q;
    assign hwm       = hwm_q;
`endif

endmodule

// File: tb/tb_avst_param_fifo.sv
// Randomised and directed bench for avst_param_fifo; covers statistics when AVST_FIFO_STATS_EN.
module tb_avst_param_fifo;

    localparam int DW    = 26;
    localparam int DEPTH = 8;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [3:0]    fill_level;
    logic          almost_full, almost_empty;
    logic          stats_clr = 1'b0;
    logic [15:0]   ovf_count;
    logic [3:0]    hwm;

    int vectors = 0;
    int errors  = 0;

    logic [DW-1:0] q[$];
    int            max_lvl;
    int            next_val;

    always #5 clk = ~clk;

    avst_param_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .fill_level   (fill_level),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`ifdef AVST_FIFO_STATS_EN
        ,
        .stats_clr    (stats_clr),
        .ovf_count    (ovf_count),
        .hwm          (hwm)
`endif
    );

`ifndef AVST_FIFO_STATS_EN
    assign ovf_count = '0;
    assign hwm       = '0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
        tick();
        vectors++;
        if ({in_ready, out_valid, fill_level, almost_empty, almost_full, out_data} !==
            {1'b1, 1'b0, 4'd0, 1'b1, 1'b0, {DW{1'b0}}}) begin
            errors++;
            $display("FAIL reset: rdy=%b vld=%b fill=%0d ae=%b af=%b data=%h, want 1 0 0 1 0 0",
                     in_ready, out_valid, fill_level, almost_empty, almost_full, out_data);
        end
    endtask

    task automatic test_fill();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            in_data = DW'(i);
            tick();
            vectors++;
            if (fill_level !== 4'(i + 1) || almost_full !== (i + 1 >= AF) ||
                almost_empty !== (i + 1 <= AE) || in_ready !== (i + 1 < DEPTH)) begin
                errors++;
                $display("FAIL fill[%0d]: fill=%0d af=%b ae=%b rdy=%b, want %0d %b %b %b", i,
                         fill_level, almost_full, almost_empty, in_ready, i + 1, i + 1 >= AF,
                         i + 1 <= AE, i + 1 < DEPTH);
            end
        end
        in_data = DW'(99);
        tick();
        in_valid = 1'b0;
        vectors++;
        if (fill_level !== 4'd8 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL overflow_drop: fill=%0d rdy=%b vld=%b, want 8 0 1",
                     fill_level, in_ready, out_valid);
        end
`ifdef AVST_FIFO_STATS_EN
        vectors++;
        if (ovf_count !== 16'd1) begin
            errors++;
            $display("FAIL ovf_count: got %0d want 1", ovf_count);
        end
`endif
    endtask

    task automatic test_drain();
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_data !== DW'(i)) begin
                errors++;
                $display("FAIL drain_data[%0d]: vld=%b data=%h, want 1 %h", i, out_valid,
                         out_data, DW'(i));
            end
            tick();
            vectors++;
            if (fill_level !== 4'(DEPTH - 1 - i) || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL drain_lvl[%0d]: fill=%0d rdy=%b, want %0d 1", i, fill_level,
                         in_ready, DEPTH - 1 - i);
            end
        end
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || almost_empty !== 1'b1) begin
            errors++;
            $display("FAIL drain_empty: vld=%b ae=%b, want 0 1", out_valid, almost_empty);
        end
    endtask

    task automatic test_single();
        in_valid = 1'b1;
        in_data  = 26'h3FFFFFF;
        tick();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || fill_level !== 4'd1) begin
            errors++;
            $display("FAIL single_edge1: vld=%b fill=%0d, want 0 1", out_valid, fill_level);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 26'h3FFFFFF) begin
            errors++;
            $display("FAIL single_edge2: vld=%b data=%h, want 1 3ffffff", out_valid, out_data);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || fill_level !== 4'd0) begin
            errors++;
            $display("FAIL single_pop: vld=%b fill=%0d, want 0 0", out_valid, fill_level);
        end
    endtask

    // One cycle against the queue model: check, drive, clock, update.
    task automatic model_cycle(input bit iv, input bit ordy);
        bit push, pop;
        int n;
        n = q.size();
        vectors++;
        if (fill_level !== 4'(n) || in_ready !== (n < DEPTH) || almost_full !== (n >= AF) ||
            almost_empty !== (n <= AE) || (out_valid && n == 0)) begin
            errors++;
            $display("FAIL model_state: fill=%0d rdy=%b af=%b ae=%b vld=%b, want fill %0d",
                     fill_level, in_ready, almost_full, almost_empty, out_valid, n);
        end
        if (out_valid && n > 0) begin
            vectors++;
            if (out_data !== q[0]) begin
                errors++;
                $display("FAIL model_data: got %h want %h", out_data, q[0]);
            end
        end
        in_valid  = iv;
        in_data   = DW'(next_val);
        out_ready = ordy;
        push = iv && (n < DEPTH);
        pop  = out_valid && ordy;
        tick();
        if (pop) void'(q.pop_front());
        if (push) begin
            q.push_back(DW'(next_val));
            next_val++;
        end
        if (q.size() > max_lvl) max_lvl = q.size();
    endtask

    task automatic test_random();
        int guard;
        void'($urandom(23));
        q.delete();
        next_val = 100;
        max_lvl  = 0;
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        for (int c = 0; c < 160; c++) begin
            model_cycle(($urandom % 4) != 0, ($urandom % 3) != 0);
        end
        guard = 0;
        while (q.size() > 0 && guard < 40) begin
            model_cycle(1'b0, 1'b1);
            guard++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        vectors++;
        if (q.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL random_drain: %0d words left, vld=%b, want 0 0", q.size(), out_valid);
        end
`ifdef AVST_FIFO_STATS_EN
        vectors++;
        if (hwm !== 4'(max_lvl)) begin
            errors++;
            $display("FAIL hwm: got %0d want %0d", hwm, max_lvl);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int guard;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_data = DW'(200 + i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        vectors++;
        if (fill_level !== 4'd5) begin
            errors++;
            $display("FAIL pre_reset_fill: got %0d want 5", fill_level);
        end
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({in_ready, out_valid, fill_level, almost_empty, almost_full, out_data} !==
            {1'b1, 1'b0, 4'd0, 1'b1, 1'b0, {DW{1'b0}}}) begin
            errors++;
            $display("FAIL async_reset: rdy=%b vld=%b fill=%0d ae=%b af=%b data=%h",
                     in_ready, out_valid, fill_level, almost_empty, almost_full, out_data);
        end
`ifdef AVST_FIFO_STATS_EN
        vectors++;
        if (ovf_count !== 16'd0 || hwm !== 4'd0) begin
            errors++;
            $display("FAIL stats_reset: ovf=%0d hwm=%0d want 0 0", ovf_count, hwm);
        end
`endif
        tick();
        reset_n = 1'b1;
        in_valid = 1'b1;
        in_data  = 26'h0ABCDEF;
        tick();
        in_valid = 1'b0;
        guard = 0;
        while (out_valid !== 1'b1 && guard < 5) begin
            tick();
            guard++;
        end
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 26'h0ABCDEF || fill_level !== 4'd1) begin
            errors++;
            $display("FAIL post_reset_first: vld=%b data=%h fill=%0d, want 1 0abcdef 1",
                     out_valid, out_data, fill_level);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        tick();
        test_drain();
        test_single();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/avst_param_fifo.md
# avst_param_fifo

Parametrised Avalon-ST buffering FIFO for the timing-adapter path of the SoC fabric, replacing fixed-width 8-deep instances. It adds configurable width and depth, a registered fill level, almost-full and almost-empty flags, and an optional statistics block. It sits between an Avalon-ST source with no backpressure tolerance and a sink that applies `ready`.

## Interface
- `DATA_WIDTH`, 26, payload width in bits.
- `DEPTH`, 8, word capacity; must be a power of two, at least 4.
- `AF_THRESH`, DEPTH-2, `almost_full` asserts when fill ≥ this value.
- `AE_THRESH`, 1, `almost_empty` asserts when fill ≤ this value.

Ports:
- `clk`  in  1  clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  source word valid.
- `in_data`  in  DATA_WIDTH  source payload.
- `in_ready`  out  1  FIFO can accept; equals !full.
- `out_ready`  in  1  sink accepts.
- `out_valid`  out  1  registered; `out_data` is valid.
- `out_data`  out  DATA_WIDTH  registered payload.
- `fill_level`  out  $clog2(DEPTH)+1  words held, 0..DEPTH, registered.
- `almost_full`, `almost_empty`  out  1 each  registered threshold flags.
- `stats_clr`, `ovf_count[15:0]`, `hwm[$clog2(DEPTH):0]`: present only with AVST_FIFO_STATS_EN.

## Operation
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- Read and write pointers are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit. Empty means the pointers are equal. Full means the address bits are equal and the wrap bits differ.
- `fill_level` is updated each edge: +1 on push only, −1 on pop only, unchanged on both or neither.
- Capacity is exactly DEPTH. `fill_level` includes the word presented on `out_data`.
- Simultaneous push and pop at any non-empty, non-full level: both take effect, and the level is unchanged.
- When full, `in_ready`=0 and in_valid is ignored; data is never overwritten.
- When empty, `out_valid`=0 and out_ready is ignored.
- Output stage is a prefetch: the memory read address advances to read pointer +1 in the same cycle as a pop. This sustains one word per cycle.
- `almost_full` and `almost_empty` are computed from the next value of the fill level, so they stay cycle-aligned with `fill_level`.
- Reset values: `out_valid`=0, `out_data`=0, `fill_level`=0, `almost_full`=0, `almost_empty`=1, `in_ready`=1 one cycle after deassertion.
- Pointers are cleared on reset. Memory contents are not reset.
- Reset asserted mid-operation discards all contents immediately and asynchronously.

## Timing
- Word pushed at edge k: `out_valid` rises after edge k+1 when the FIFO was empty. Latency is 2 edges, with a 1-cycle bubble.
- Continuous push and pop: 1 word per cycle, no bubbles.
- Pop at edge k when 1 word remains and no push: `out_valid`=0 after edge k.
- `in_ready` is driven combinationally from registered state only. There is no combinational path from out_ready to in_ready.
- Pop at edge k from full: `in_ready`=1 after edge k.

## Configuration
- Macro AVST_FIFO_STATS_EN.
- When defined, `ovf_count` counts cycles with in_valid && !in_ready. It is a 16-bit counter that saturates at 0xFFFF.
- When defined, `hwm` holds the maximum `fill_level` seen.
- `stats_clr` (synchronous) zeroes both; if a count event occurs in the same cycle, the clear takes priority.
- Both statistics reset to 0.
- When undefined, the statistics ports and logic are absent. Core behaviour is identical in both builds.

## Structure
- Package `avst_fifo_pkg` holds:
  - localparam function for the fill width;
  - default DEPTH/DATA_WIDTH constants;
  - the statistics counter width (16).
- Sub-module `avst_fifo_ram`: simple dual-port RAM, synchronous write, synchronous read, DATA_WIDTH × DEPTH, with no reset.
- Pointer, flag and output-register logic stays in the top module.

## Test plan
- Reset release with DEPTH=8, WIDTH=26 → `in_ready`=1, `out_valid`=0, `fill_level`=0, `almost_empty`=1, `almost_full`=0.
- Push 8 words (0..7) with out_ready=0 → `fill_level` goes 1..8, `almost_full`=1 at 6, `in_ready`=0 after the 8th push; a 9th in_valid is dropped (`ovf_count`=1 with the macro).
- From full, out_ready=1 and in_valid=0 → words 0..7 come out on consecutive cycles, `in_ready`=1 after the first pop, `out_valid`=0 after the 8th.
- Single word 0x3FFFFFF into an empty FIFO → `out_valid`=1 exactly 2 edges later with data 0x3FFFFFF.
- Random in_valid/out_ready (seed 23) for 160 cycles → output is the in-order incrementing sequence, `fill_level` matches the scoreboard, and `hwm` equals the maximum observed level.
- Assert reset_n at fill 5 → all outputs take their reset values asynchronously, and the next pushed word is the first one output.
